// File: rtl/alu_writeback.sv
// Writeback stage behind the 8-bit 6502 ALU: one-entry pending register, A/X/Y commit and P flag merge.
// Optional macro ALU_WB_FWD_EN forwards the committing result and carry combinationally.
module alu_writeback #(
  parameter int          DATA_W  = 8,
  parameter logic [7:0]  P_RESET = 8'h24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_c,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_v,
  input  logic [1:0]        in_dest,
  input  logic [3:0]        in_flag_mask,
  input  logic              stall,
  input  logic [2:0]        flag_op,
  input  logic              p_load,
  input  logic [7:0]        p_din,
  input  logic              push_brk,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_x,
  output logic [DATA_W-1:0] reg_y,
  output logic [7:0]        p_out,
  output logic [7:0]        p_push,
  output logic              carry_out,
  output logic              busy
);

  // Handshake: a result transfers on a clk edge where in_valid and in_ready are both 1;
  // in_ready depends only on the pending slot and stall, never on in_valid.
  logic              pend_valid;
  logic [DATA_W-1:0] pend_result;
  logic              pend_c, pend_z, pend_n, pend_v;
  logic [1:0]        pend_dest;
  logic [3:0]        pend_mask;

  logic [DATA_W-1:0] a_q, x_q, y_q;
  logic              n_q, v_q, d_q, i_q, z_q, c_q;
  logic              n_d, v_d, d_d, i_d, z_d, c_d;

  logic commit;
  logic accept;
  logic unused_bits;

  assign commit      = pend_valid & ~stall;
  assign in_ready    = ~pend_valid | commit;
  assign accept      = in_valid & in_ready;
  assign busy        = pend_valid;
  assign unused_bits = ^p_din[5:4];

  // Next P: commit merge, then flag instruction, then a full load on top.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (commit) begin
      if (pend_mask[3]) n_d = pend_n;
      if (pend_mask[2]) v_d = pend_v;
      if (pend_mask[1]) z_d = pend_z;
      if (pend_mask[0]) c_d = pend_c;
    end
    case (flag_op)
      3'd1:    c_d = 1'b0;
      3'd2:    c_d = 1'b1;
      3'd3:    i_d = 1'b0;
      3'd4:    i_d = 1'b1;
      3'd5:    v_d = 1'b0;
      3'd6:    d_d = 1'b0;
      3'd7:    d_d = 1'b1;
      default: ;
    endcase
    if (p_load) begin
      n_d = p_din[7];
      v_d = p_din[6];
      d_d = p_din[3];
      i_d = p_din[2];
      z_d = p_din[1];
      c_d = p_din[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_result <= '0;
      pend_c      <= 1'b0;
      pend_z      <= 1'b0;
      pend_n      <= 1'b0;
      pend_v      <= 1'b0;
      pend_dest   <= 2'd0;
      pend_mask   <= 4'd0;
    end else if (accept) begin
      pend_valid  <= 1'b1;
      pend_result <= in_result;
      pend_c      <= in_c;
      pend_z      <= in_z;
      pend_n      <= in_n;
      pend_v      <= in_v;
      pend_dest   <= in_dest;
      pend_mask   <= in_flag_mask;
    end else if (commit) begin
      pend_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (commit) begin
      case (pend_dest)
        2'd1:    a_q <= pend_result;
        2'd2:    x_q <= pend_result;
        2'd3:    y_q <= pend_result;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= P_RESET[7];
      v_q <= P_RESET[6];
      d_q <= P_RESET[3];
      i_q <= P_RESET[2];
      z_q <= P_RESET[1];
      c_q <= P_RESET[0];
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign p_out  = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
  assign p_push = {p_out[7:5], push_brk, p_out[3:0]};

`ifdef ALU_WB_FWD_EN
  // Bypass the committing entry so a dependent ALU op can issue in the commit cycle.
  assign reg_a     = (commit && pend_dest == 2'd1) ? pend_result : a_q;
  assign reg_x     = (commit && pend_dest == 2'd2) ? pend_result : x_q;
  assign reg_y     = (commit && pend_dest == 2'd3) ? pend_result : y_q;
  assign carry_out = (commit && pend_mask[0]) ? pend_c : c_q;
`else
  assign reg_a     = a_q;
  assign reg_x     = x_q;
  assign reg_y     = y_q;
  assign carry_out = c_q;
`endif

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the 8-bit 6502 ALU.
- Captures one ALU result plus its C/Z/N/V flags through a valid/ready handshake and holds it in a 1-entry pending register.
- Commits the result to A, X or Y and merges the masked flags into the processor status register (P).
- Feeds the current carry back to the ALU, supplies P for PHP/BRK pushes, and accepts P loads (PLP/RTI) and explicit flag instructions.

Parameters:
- DATA_W, 8, datapath width; only 8 is supported.
- P_RESET, 8'h24, P value after reset (I=1; bit5 reads 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept a result this cycle
- in_result  in  8  ALU Y
- in_c / in_z / in_n / in_v  in  1 each  ALU flags
- in_dest  in  2  0 = none, 1 = A, 2 = X, 3 = Y
- in_flag_mask  in  4  {N,V,Z,C} update enables
- stall  in  1  blocks commit (for example, memory busy)
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
- p_load  in  1  load P from p_din
- p_din  in  8  pulled status byte
- push_brk  in  1  B bit value for p_push
- reg_a / reg_x / reg_y  out  8 each  architectural registers
- p_out  out  8  status, bit5 = 1, bit4 = 0
- p_push  out  8  p_out with bit4 = push_brk
- carry_out  out  1  P.C to ALU carry-in
- busy  out  1  pending entry held

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge):
  - reg_a, reg_x, reg_y = 0; pending valid = 0.
  - P = P_RESET, so p_out = 8'h24 and carry_out = 0.
  - in_ready = 1, busy = 0.
  - Reset mid-operation discards any pending entry with no commit and wins over every other input.
- Stored state: N, V, D, I, Z, C flops. Bit5 and bit4 are not stored.
- Handshake:
  - commit = pend_valid & ~stall.
  - in_ready = ~pend_valid | commit.
  - Accept when in_valid & in_ready: capture result, flags, dest and mask into the pending register on the edge.
  - Back-to-back accept and commit in the same cycle sustains 1 result/cycle.
  - Latency: accept at edge k, visible on reg_* and p_out after edge k+1 if stall = 0.
  - stall holds the pending entry indefinitely; no loss and no duplicate commit.
  - in_valid while in_ready = 0: the input is ignored; upstream must hold it.
- Commit:
  - Write the pending result to the selected register; dest 0 writes nothing.
  - Each flag with its mask bit set takes the pending value; others are kept.
  - D and I are never touched by commit.
- Same-cycle priority for the next P, in order:
  1. Commit merge.
  2. flag_op applied on top; for example, commit setting C=1 with CLC gives C=0.
  3. p_load overrides all six stored flags from p_din[7,6,3,2,1,0].
- p_load and flag_op act regardless of stall and pending state. Register writes from commit still occur under p_load.
- Outputs:
  - p_out = {N,V,1,0,D,I,Z,C}, registered.
  - p_push is combinational from p_out and push_brk.
  - carry_out reflects the committed P.C only, never the pending entry.

Optional Feature:
- Macro: ALU_WB_FWD_EN.
- Defined:
  - reg_a/x/y and carry_out forward the pending value combinationally while commit = 1, for the dest register and masked C respectively.
  - This removes the one-cycle read-after-write bubble.
- Undefined: all outputs are purely registered as described above.
- in_ready, busy and the P update order are identical in both builds.

Test Plan:
- Reset: drive rst with in_valid = 1 in flight -> after the edge, p_out = 8'h24, reg_a/x/y = 0, in_ready = 1, busy = 0; no register written.
- Basic commit: in_result = 8'h80, dest = A, mask = 4'b1010 (N,Z), n = 1, z = 0, stall = 0 -> next cycle reg_a = 8'h80, p_out = 8'hA4, carry_out = 0.
- Stall hold: accept 8'h05 to X with stall = 1 for 3 cycles, second in_valid presented -> in_ready = 0 and reg_x unchanged for those 3 cycles; after stall drops, reg_x = 8'h05 one cycle later, then the second result commits the following cycle.
- Flag priority: commit with C = 1, mask = C, same cycle as flag_op = CLC -> C = 0. Repeat with p_load, p_din = 8'hFF -> p_out = 8'hEF.
- Push: P = 8'h24 with push_brk = 1 -> p_push = 8'h34; with push_brk = 0 -> p_push = 8'h24.
- Throughput and forwarding: 4 back-to-back results 8'h01..8'h04 to Y -> reg_y takes each value on consecutive cycles. With ALU_WB_FWD_EN defined, reg_y equals each value in its commit cycle.
